// File: rtl/algo_pque_ptr_alloc.sv
// algo_pque_ptr_alloc
// Initiator-side client for the pque push/pop interface. Every accepted
// enqueue takes a link pointer from an internal free list and pushes it;
// every accepted dequeue pops, and the pointer the pque returns is handed
// to the user and recycled into the free list. Fresh pointers (never issued
// since reset) are handed out first; after that, recycled pointers come out
// of a FIFO in return order. POP_DELAY must be at least 1.
module algo_pque_ptr_alloc #(
  parameter int NUMADDR   = 256,
  parameter int BITADDR   = 8,
  parameter int NUMQPRT   = 64,
  parameter int BITQPRT   = 6,
  parameter int BITQCNT   = BITADDR + 1,
  parameter int POP_DELAY = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               pque_ready,
  output logic               ready,
  input  logic               enq_vld,
  input  logic [BITQPRT-1:0] enq_prt,
  output logic               enq_rdy,
  input  logic               deq_vld,
  input  logic [BITQPRT-1:0] deq_prt,
  output logic               deq_rdy,
  output logic               deq_out_vld,
  output logic [BITADDR-1:0] deq_out_ptr,
  output logic               deq_out_emp,
  output logic               push,
  output logic [BITQPRT-1:0] pu_prt,
  output logic [BITADDR-1:0] pu_ptr,
  output logic               pop,
  output logic               po_ndq,
  output logic [BITQPRT-1:0] po_prt,
  input  logic               po_pvld,
  input  logic [BITADDR-1:0] po_ptr,
  output logic [BITQCNT-1:0] free_cnt,
  output logic               err
);

  if (NUMQPRT > (1 << BITQPRT)) begin : g_bad_prt
    $error("BITQPRT is too narrow to encode NUMQPRT priorities");
  end

  localparam logic [BITQCNT-1:0] NUM_Q  = BITQCNT'(NUMADDR);
  localparam logic [BITADDR-1:0] LAST_A = BITADDR'(NUMADDR - 1);

  // Pointer increment that wraps by compare, so NUMADDR need not be 2^n.
  function automatic logic [BITADDR-1:0] wrap_inc(input logic [BITADDR-1:0] p);
    return (p == LAST_A) ? '0 : p + 1'b1;
  endfunction

  logic [BITQCNT-1:0] nxt_new;
  logic [BITQCNT-1:0] fifo_cnt;
  logic [BITADDR-1:0] head;
  logic [BITADDR-1:0] tail;
  logic [BITADDR-1:0] fifo_mem [NUMADDR];
  logic [POP_DELAY:0] pop_pipe;

  logic               enq_acc;
  logic               deq_acc;
  logic               from_fresh;
  logic               alloc_fifo;
  logic [BITADDR-1:0] alloc_ptr;
  logic               ret_vld;
  logic               rcy_try;
  logic               rcy_ok;
  logic               rcy_drop;
  logic               spurious;

  assign ready   = rst & pque_ready;
  assign enq_rdy = ready & (free_cnt != '0);
  assign deq_rdy = ready;
  assign po_ndq  = 1'b0;

  assign enq_acc    = enq_vld & enq_rdy;
  assign deq_acc    = deq_vld & deq_rdy;
  assign from_fresh = (nxt_new != NUM_Q);
  assign alloc_fifo = enq_acc & ~from_fresh;
  assign alloc_ptr  = from_fresh ? nxt_new[BITADDR-1:0] : fifo_mem[head];

  // The oldest pipe stage lines up with the cycle po_pvld belongs to.
  assign ret_vld  = pop_pipe[POP_DELAY];
  assign rcy_try  = ret_vld & po_pvld;
  assign rcy_ok   = rcy_try & (fifo_cnt != NUM_Q);
  assign rcy_drop = rcy_try & ~rcy_ok;
  assign spurious = po_pvld & ~ret_vld;

  // Recycle storage: data only, no reset needed.
  always_ff @(posedge clk) begin
    if (rcy_ok) fifo_mem[tail] <= po_ptr;
  end

  // Control state, pque request registers and user result registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      push        <= 1'b0;
      pu_prt      <= '0;
      pu_ptr      <= '0;
      pop         <= 1'b0;
      po_prt      <= '0;
      deq_out_vld <= 1'b0;
      deq_out_ptr <= '0;
      deq_out_emp <= 1'b0;
      err         <= 1'b0;
      nxt_new     <= '0;
      fifo_cnt    <= '0;
      head        <= '0;
      tail        <= '0;
      pop_pipe    <= '0;
      free_cnt    <= NUM_Q;
    end else begin
      push <= enq_acc;
      if (enq_acc) begin
        pu_prt <= enq_prt;
        pu_ptr <= alloc_ptr;
      end
      pop <= deq_acc;
      if (deq_acc) po_prt <= deq_prt;

      pop_pipe <= {pop_pipe[POP_DELAY-1:0], deq_acc};

      deq_out_vld <= ret_vld;
      if (ret_vld) begin
        deq_out_ptr <= po_pvld ? po_ptr : '0;
        deq_out_emp <= ~po_pvld;
      end

      if (enq_acc && from_fresh) nxt_new <= nxt_new + 1'b1;
      if (alloc_fifo) head <= wrap_inc(head);
      if (rcy_ok) tail <= wrap_inc(tail);

      // A same-cycle allocation and recycle cancel out in both counts.
      case ({rcy_ok, alloc_fifo})
        2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
        2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
        default: fifo_cnt <= fifo_cnt;
      endcase
      case ({rcy_ok, enq_acc})
        2'b10:   free_cnt <= free_cnt + 1'b1;
        2'b01:   free_cnt <= free_cnt - 1'b1;
        default: free_cnt <= free_cnt;
      endcase

      if (spurious || rcy_drop) err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_algo_pque_ptr_alloc.sv
// Bench for algo_pque_ptr_alloc: a stub pque answers each pop POP_DELAY
// cycles later from a response queue; expected pushes, pops and dequeue
// results are queued when stimulus is driven and compared when they appear.
`timescale 1ns/1ps
module tb_algo_pque_ptr_alloc;

  localparam int PD = 3;

  typedef struct { int cyc; logic [5:0] prt; logic [7:0] ptr; } push_t;
  typedef struct { int cyc; logic [7:0] ptr; logic emp; } deq_t;
  typedef struct { logic pvld; logic [7:0] ptr; } rsp_t;
  typedef struct { int cyc; logic [7:0] ptr; } ret_t;

  logic       clk, rst, pque_ready, ready;
  logic       enq_vld, enq_rdy, deq_vld, deq_rdy;
  logic [5:0] enq_prt, deq_prt, pu_prt, po_prt;
  logic       deq_out_vld, deq_out_emp, push, pop, po_ndq, po_pvld, err;
  logic [7:0] deq_out_ptr, pu_ptr, po_ptr;
  logic [8:0] free_cnt;

  logic       stub_vld, spur;
  logic [7:0] stub_ptr;
  logic [1:0] stub_sr;

  int    checks, errors, cyc;
  push_t exp_push[$];
  push_t exp_pop[$];
  deq_t  exp_deq[$];
  rsp_t  rsp[$];

  algo_pque_ptr_alloc dut (
    .clk(clk), .rst(rst), .pque_ready(pque_ready), .ready(ready),
    .enq_vld(enq_vld), .enq_prt(enq_prt), .enq_rdy(enq_rdy),
    .deq_vld(deq_vld), .deq_prt(deq_prt), .deq_rdy(deq_rdy),
    .deq_out_vld(deq_out_vld), .deq_out_ptr(deq_out_ptr), .deq_out_emp(deq_out_emp),
    .push(push), .pu_prt(pu_prt), .pu_ptr(pu_ptr),
    .pop(pop), .po_ndq(po_ndq), .po_prt(po_prt),
    .po_pvld(po_pvld), .po_ptr(po_ptr),
    .free_cnt(free_cnt), .err(err)
  );

  assign po_pvld = stub_vld | spur;
  assign po_ptr  = stub_ptr;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stub pque: a pop seen in cycle T+1 is answered in cycle T+1+PD.
  always @(posedge clk) begin
    if (!rst) begin
      stub_sr  <= '0;
      stub_vld <= 1'b0;
      stub_ptr <= '0;
      rsp.delete();
    end else begin
      stub_sr <= {stub_sr[0], pop};
      if (stub_sr[1] && rsp.size() != 0) begin
        stub_vld <= rsp[0].pvld;
        stub_ptr <= rsp[0].ptr;
        void'(rsp.pop_front());
      end else begin
        stub_vld <= 1'b0;
        stub_ptr <= '0;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic test_reset();
    rst = 1'b0; pque_ready = 1'b1; spur = 1'b0;
    enq_vld = 1'b0; enq_prt = '0; deq_vld = 1'b0; deq_prt = '0;
    step(); step();
    checks++;
    if ({push, pop, pu_prt, pu_ptr, po_prt, deq_out_vld, deq_out_ptr, deq_out_emp, err} !== '0) begin
      errors++;
      $display("FAIL reset_outs: got push=%b pop=%b pu_prt=%0d pu_ptr=%0d po_prt=%0d dov=%b dop=%0d doe=%b err=%b, want all 0",
               push, pop, pu_prt, pu_ptr, po_prt, deq_out_vld, deq_out_ptr, deq_out_emp, err);
    end
    checks++;
    if (free_cnt !== 9'd256) begin errors++; $display("FAIL reset_free: got %0d want 256", free_cnt); end
    checks++;
    if ({ready, enq_rdy, deq_rdy, po_ndq} !== 4'b0000) begin
      errors++; $display("FAIL reset_rdy: got ready/enq/deq/ndq=%b want 0000", {ready, enq_rdy, deq_rdy, po_ndq});
    end
    rst = 1'b1; pque_ready = 1'b0;
    #1;
    checks++;
    if (ready !== 1'b0) begin errors++; $display("FAIL ready_pque_low: got %b want 0", ready); end
    pque_ready = 1'b1;
    #1;
    checks++;
    if ({ready, enq_rdy, deq_rdy} !== 3'b111) begin
      errors++; $display("FAIL ready_up: got ready/enq/deq=%b want 111", {ready, enq_rdy, deq_rdy});
    end
  endtask

  task automatic test_enq_basic();
    push_t pe;
    for (int i = 0; i < 6; i++) begin
      enq_vld = (i < 3); enq_prt = 6'd5;
      if (i < 3) begin pe.cyc = cyc + 1; pe.prt = 6'd5; pe.ptr = 8'(i); exp_push.push_back(pe); end
      step();
      if (exp_push.size() != 0 && exp_push[0].cyc == cyc) begin
        checks++;
        if (push !== 1'b1 || pu_prt !== exp_push[0].prt || pu_ptr !== exp_push[0].ptr) begin
          errors++;
          $display("FAIL enq_push@%0d: got push=%b prt=%0d ptr=%0d want prt=%0d ptr=%0d",
                   cyc, push, pu_prt, pu_ptr, exp_push[0].prt, exp_push[0].ptr);
        end
        void'(exp_push.pop_front());
      end else begin
        checks++;
        if (push !== 1'b0) begin errors++; $display("FAIL enq_idle@%0d: got push=%b want 0", cyc, push); end
      end
    end
    enq_vld = 1'b0;
    checks++;
    if (free_cnt !== 9'd253) begin errors++; $display("FAIL enq_free: got %0d want 253", free_cnt); end
  endtask

  task automatic test_exhaust();
    push_t pe;
    int    exp_free = 253;
    int    nxt = 3;
    for (int i = 0; i < 257; i++) begin
      enq_vld = 1'b1; enq_prt = 6'(i);
      checks++;
      if (enq_rdy !== (exp_free != 0)) begin
        errors++; $display("FAIL exh_rdy@%0d: got %b want %b", cyc, enq_rdy, exp_free != 0);
      end
      if (exp_free != 0) begin
        pe.cyc = cyc + 1; pe.prt = 6'(i); pe.ptr = 8'(nxt); exp_push.push_back(pe);
        nxt++; exp_free--;
      end
      step();
      if (exp_push.size() != 0 && exp_push[0].cyc == cyc) begin
        checks++;
        if (push !== 1'b1 || pu_prt !== exp_push[0].prt || pu_ptr !== exp_push[0].ptr) begin
          errors++;
          $display("FAIL exh_push@%0d: got push=%b prt=%0d ptr=%0d want prt=%0d ptr=%0d",
                   cyc, push, pu_prt, pu_ptr, exp_push[0].prt, exp_push[0].ptr);
        end
        void'(exp_push.pop_front());
      end else begin
        checks++;
        if (push !== 1'b0) begin errors++; $display("FAIL exh_extra_push@%0d: got push=%b want 0", cyc, push); end
      end
      checks++;
      if (free_cnt !== 9'(exp_free)) begin
        errors++; $display("FAIL exh_free@%0d: got %0d want %0d", cyc, free_cnt, exp_free);
      end
    end
    enq_vld = 1'b0;
  endtask

  task automatic test_deq_recycle();
    rsp_t re;
    re.pvld = 1'b1; re.ptr = 8'd1; rsp.push_back(re);
    deq_vld = 1'b1; deq_prt = 6'd5;
    step();
    deq_vld = 1'b0;
    checks++;
    if (pop !== 1'b1 || po_prt !== 6'd5 || po_ndq !== 1'b0) begin
      errors++; $display("FAIL deq_pop: got pop=%b prt=%0d ndq=%b want 1/5/0", pop, po_prt, po_ndq);
    end
    step();
    checks++;
    if (pop !== 1'b0) begin errors++; $display("FAIL deq_pop_pulse: got pop=%b want 0", pop); end
    step(); step();
    checks++;
    if (deq_out_vld !== 1'b0 || free_cnt !== 9'd0) begin
      errors++; $display("FAIL deq_early: got vld=%b free=%0d want 0/0", deq_out_vld, free_cnt);
    end
    step();
    checks++;
    if (deq_out_vld !== 1'b1 || deq_out_ptr !== 8'd1 || deq_out_emp !== 1'b0 || free_cnt !== 9'd1) begin
      errors++;
      $display("FAIL deq_out: got vld=%b ptr=%0d emp=%b free=%0d want 1/1/0/1",
               deq_out_vld, deq_out_ptr, deq_out_emp, free_cnt);
    end
    step();
    checks++;
    if (deq_out_vld !== 1'b0) begin errors++; $display("FAIL deq_out_pulse: got vld=%b want 0", deq_out_vld); end
  endtask

  task automatic test_traffic();
    bit         en [48];
    bit         dq [48];
    bit         pv [48];
    logic [7:0] rp [48];
    logic [7:0] mfifo[$];
    ret_t       pend[$];
    push_t      pe;
    deq_t       de;
    rsp_t       re;
    ret_t       rt;
    for (int k = 0; k < 48; k++) begin en[k] = 0; dq[k] = 0; pv[k] = 0; rp[k] = '0; end
    en[0] = 1;
    dq[1] = 1; pv[1] = 1; rp[1] = 8'd7;
    dq[2] = 1; pv[2] = 1; rp[2] = 8'd3;
    en[6] = 1; en[7] = 1;
    dq[8] = 1;
    en[9] = 1;
    dq[10] = 1; pv[10] = 1; rp[10] = 8'd9;
    en[15] = 1; dq[15] = 1; pv[15] = 1; rp[15] = 8'd4;
    dq[16] = 1; pv[16] = 1; rp[16] = 8'd6;
    en[20] = 1; en[21] = 1;
    for (int k = 22; k < 32; k++) begin en[k] = 1; dq[k] = 1; pv[k] = 1; rp[k] = 8'(20 + k); end
    mfifo.push_back(8'd1);
    for (int k = 0; k < 48; k++) begin
      enq_vld = en[k]; enq_prt = 6'(k);
      deq_vld = dq[k]; deq_prt = 6'(63 - k);
      checks++;
      if (enq_rdy !== (mfifo.size() != 0)) begin
        errors++; $display("FAIL trf_rdy@%0d: got %b want %b", cyc, enq_rdy, mfifo.size() != 0);
      end
      if (en[k] && mfifo.size() != 0) begin
        pe.cyc = cyc + 1; pe.prt = 6'(k); pe.ptr = mfifo.pop_front(); exp_push.push_back(pe);
      end
      if (dq[k]) begin
        re.pvld = pv[k]; re.ptr = rp[k]; rsp.push_back(re);
        pe.cyc = cyc + 1; pe.prt = 6'(63 - k); pe.ptr = '0; exp_pop.push_back(pe);
        de.cyc = cyc + PD + 2; de.ptr = pv[k] ? rp[k] : 8'd0; de.emp = !pv[k]; exp_deq.push_back(de);
        if (pv[k]) begin rt.cyc = cyc + PD + 2; rt.ptr = rp[k]; pend.push_back(rt); end
      end
      step();
      while (pend.size() != 0 && pend[0].cyc <= cyc) begin
        mfifo.push_back(pend[0].ptr);
        void'(pend.pop_front());
      end
      if (exp_push.size() != 0 && exp_push[0].cyc == cyc) begin
        checks++;
        if (push !== 1'b1 || pu_prt !== exp_push[0].prt || pu_ptr !== exp_push[0].ptr) begin
          errors++;
          $display("FAIL trf_push@%0d: got push=%b prt=%0d ptr=%0d want prt=%0d ptr=%0d",
                   cyc, push, pu_prt, pu_ptr, exp_push[0].prt, exp_push[0].ptr);
        end
        void'(exp_push.pop_front());
      end else begin
        checks++;
        if (push !== 1'b0) begin errors++; $display("FAIL trf_push_idle@%0d: got push=%b want 0", cyc, push); end
      end
      if (exp_pop.size() != 0 && exp_pop[0].cyc == cyc) begin
        checks++;
        if (pop !== 1'b1 || po_prt !== exp_pop[0].prt) begin
          errors++; $display("FAIL trf_pop@%0d: got pop=%b prt=%0d want prt=%0d", cyc, pop, po_prt, exp_pop[0].prt);
        end
        void'(exp_pop.pop_front());
      end else begin
        checks++;
        if (pop !== 1'b0) begin errors++; $display("FAIL trf_pop_idle@%0d: got pop=%b want 0", cyc, pop); end
      end
      if (exp_deq.size() != 0 && exp_deq[0].cyc == cyc) begin
        checks++;
        if (deq_out_vld !== 1'b1 || deq_out_ptr !== exp_deq[0].ptr || deq_out_emp !== exp_deq[0].emp) begin
          errors++;
          $display("FAIL trf_deq@%0d: got vld=%b ptr=%0d emp=%b want ptr=%0d emp=%b",
                   cyc, deq_out_vld, deq_out_ptr, deq_out_emp, exp_deq[0].ptr, exp_deq[0].emp);
        end
        void'(exp_deq.pop_front());
      end else begin
        checks++;
        if (deq_out_vld !== 1'b0) begin errors++; $display("FAIL trf_deq_idle@%0d: got vld=%b want 0", cyc, deq_out_vld); end
      end
      checks++;
      if (free_cnt !== 9'(mfifo.size())) begin
        errors++; $display("FAIL trf_free@%0d: got %0d want %0d", cyc, free_cnt, mfifo.size());
      end
    end
    enq_vld = 1'b0; deq_vld = 1'b0;
  endtask

  task automatic test_err();
    checks++;
    if (err !== 1'b0) begin errors++; $display("FAIL err_quiet: got %b want 0", err); end
    spur = 1'b1;
    step();
    spur = 1'b0;
    checks++;
    if (err !== 1'b1) begin errors++; $display("FAIL err_set: got %b want 1", err); end
    step(); step(); step(); step();
    checks++;
    if (err !== 1'b1) begin errors++; $display("FAIL err_sticky: got %b want 1", err); end
  endtask

  task automatic test_reset_mid();
    rsp_t re;
    re.pvld = 1'b1; re.ptr = 8'd1; rsp.push_back(re);
    enq_vld = 1'b1; enq_prt = 6'd2; deq_vld = 1'b1; deq_prt = 6'd2;
    step();
    deq_vld = 1'b0;
    step();
    rst = 1'b0;
    step();
    checks++;
    if ({push, pop, pu_prt, pu_ptr, po_prt, deq_out_vld, deq_out_ptr, deq_out_emp, err} !== '0) begin
      errors++;
      $display("FAIL midrst_outs: got push=%b pop=%b pu_prt=%0d pu_ptr=%0d po_prt=%0d dov=%b dop=%0d doe=%b err=%b, want all 0",
               push, pop, pu_prt, pu_ptr, po_prt, deq_out_vld, deq_out_ptr, deq_out_emp, err);
    end
    checks++;
    if (free_cnt !== 9'd256 || ready !== 1'b0 || enq_rdy !== 1'b0) begin
      errors++; $display("FAIL midrst_free: got free=%0d ready=%b enq_rdy=%b want 256/0/0", free_cnt, ready, enq_rdy);
    end
    enq_vld = 1'b0;
    step();
    rst = 1'b1;
    for (int i = 0; i < PD + 3; i++) step();
    checks++;
    if (err !== 1'b0 || pop !== 1'b0) begin
      errors++; $display("FAIL midrst_quiet: got err=%b pop=%b want 0/0", err, pop);
    end
    enq_vld = 1'b1; enq_prt = 6'd3;
    step();
    enq_vld = 1'b0;
    checks++;
    if (push !== 1'b1 || pu_ptr !== 8'd0 || pu_prt !== 6'd3 || free_cnt !== 9'd255) begin
      errors++;
      $display("FAIL midrst_enq: got push=%b ptr=%0d prt=%0d free=%0d want 1/0/3/255", push, pu_ptr, pu_prt, free_cnt);
    end
  endtask

  initial begin
    checks = 0; errors = 0; cyc = 0;
    test_reset();
    test_enq_basic();
    test_exhaust();
    test_deq_recycle();
    test_traffic();
    test_err();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
